// File: rtl/axi_pkg.sv
// Shared AXI4 constants, response codes and burst-master state type.
// Used by the burst master and anything that decodes its status.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } mst_state_e;

  function automatic logic [2:0] decode_size(input int unsigned nbytes);
    logic [2:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) begin
      if (nbytes == (32'd1 << i)) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/axi_burst_master.sv
// Single-outstanding AXI4 INCR burst master with command/stream front end.
// Reports per-transaction status including protocol errors from the slave.
module axi_burst_master
  import axi_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int MASTER_ID  = 0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  input  logic [DATA_WIDTH-1:0]   s_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_wstrb,
  input  logic                    s_wvalid,
  output logic                    s_wready,
  output logic [DATA_WIDTH-1:0]   m_rdata,
  output logic                    m_rlast,
  output logic                    m_rvalid,
  input  logic                    m_rready,
  output logic                    done,
  output logic [1:0]              done_resp,
  output logic [ID_WIDTH-1:0]     awid,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic                    awlock,
  output logic [3:0]              awcache,
  output logic [2:0]              awprot,
  output logic [3:0]              awqos,
  output logic [3:0]              awregion,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH/8-1:0] wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  output logic [ID_WIDTH-1:0]     arid,
  output logic [ADDR_WIDTH-1:0]   araddr,
  output logic [7:0]              arlen,
  output logic [2:0]              arsize,
  output logic [1:0]              arburst,
  output logic                    arlock,
  output logic [3:0]              arcache,
  output logic [2:0]              arprot,
  output logic [3:0]              arqos,
  output logic [3:0]              arregion,
  output logic                    arvalid,
  input  logic                    arready,
  input  logic [ID_WIDTH-1:0]     rid,
  input  logic [DATA_WIDTH-1:0]   rdata,
  input  logic [1:0]              rresp,
  input  logic                    rlast,
  input  logic                    rvalid,
  output logic                    rready
);

  localparam int NBYTES = DATA_WIDTH / 8;
  localparam logic [2:0] SIZE = decode_size(NBYTES);
  localparam logic [ID_WIDTH-1:0] MID = ID_WIDTH'(MASTER_ID);
  localparam logic [ADDR_WIDTH-1:0] AMASK = ~ADDR_WIDTH'(NBYTES - 1);

  function automatic logic crosses_4k(input logic [11:0] a,
                                      input logic [7:0]  l);
    logic [31:0] w_end;
    w_end = 32'(a) + (32'(l) + 32'd1) * 32'(NBYTES);
    return w_end > 32'd4096;
  endfunction

  mst_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [7:0]            r_beat;
  logic [1:0]            r_status;
  logic                  r_awvalid;
  logic                  r_arvalid;

  logic [ADDR_WIDTH-1:0] w_addr_al;
  logic                  w_wr_ph;
  logic                  w_rd_ph;
  logic                  w_last_beat;
  logic                  w_rd_perr;
  logic [1:0]            w_rd_worst;
  logic [1:0]            w_rd_status;

  assign w_addr_al   = cmd_addr & AMASK;
  assign w_wr_ph     = (r_state == WR_DATA);
  assign w_rd_ph     = (r_state == RD_DATA);
  assign w_last_beat = (r_beat == 8'd0);

  // Worst response wins; a protocol violation is at least SLVERR.
  always_comb begin
    w_rd_perr   = (rid != MID) || (rlast != w_last_beat);
    w_rd_worst  = (rresp > r_status) ? rresp : r_status;
    w_rd_status = w_rd_worst;
    if (w_rd_perr && (w_rd_worst < RESP_SLVERR)) w_rd_status = RESP_SLVERR;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_status  <= RESP_OKAY;
      r_awvalid <= 1'b0;
      r_arvalid <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (cmd_valid) begin
            r_addr <= w_addr_al;
            r_len  <= cmd_len;
            r_beat <= cmd_len;
            if (crosses_4k(w_addr_al[11:0], cmd_len)) begin
              r_status <= RESP_SLVERR;
              r_state  <= DONE;
            end else if (cmd_write) begin
              r_awvalid <= 1'b1;
              r_state   <= WR_ADDR;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= RD_ADDR;
            end
          end
        end
        WR_ADDR: begin
          if (awready) begin
            r_awvalid <= 1'b0;
            r_state   <= WR_DATA;
          end
        end
        WR_DATA: begin
          if (s_wvalid && wready) begin
            if (w_last_beat) r_state <= WR_RESP;
            else r_beat <= r_beat - 8'd1;
          end
        end
        WR_RESP: begin
          if (bvalid) begin
            r_status <= (bid != MID) ? RESP_SLVERR : bresp;
            r_state  <= DONE;
          end
        end
        RD_ADDR: begin
          if (arready) begin
            r_arvalid <= 1'b0;
            r_state   <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rvalid && m_rready) begin
            r_status <= w_rd_status;
            if (w_last_beat) r_state <= DONE;
            else r_beat <= r_beat - 8'd1;
          end
        end
        DONE: begin
          r_status <= RESP_OKAY;
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_ready = aresetn && (r_state == IDLE);
  assign done      = (r_state == DONE);
  assign done_resp = done ? r_status : RESP_OKAY;

  assign awid     = MID;
  assign awaddr   = r_addr;
  assign awlen    = r_len;
  assign awsize   = SIZE;
  assign awburst  = BURST_INCR;
  assign awlock   = 1'b0;
  assign awcache  = 4'd0;
  assign awprot   = 3'd0;
  assign awqos    = 4'd0;
  assign awregion = 4'd0;
  assign awvalid  = r_awvalid;

  assign wdata    = s_wdata;
  assign wstrb    = s_wstrb;
  assign wlast    = w_wr_ph && w_last_beat;
  assign wvalid   = w_wr_ph && s_wvalid;
  assign s_wready = w_wr_ph && wready;
  assign bready   = (r_state == WR_RESP);

  assign arid     = MID;
  assign araddr   = r_addr;
  assign arlen    = r_len;
  assign arsize   = SIZE;
  assign arburst  = BURST_INCR;
  assign arlock   = 1'b0;
  assign arcache  = 4'd0;
  assign arprot   = 3'd0;
  assign arqos    = 4'd0;
  assign arregion = 4'd0;
  assign arvalid  = r_arvalid;

  assign m_rdata  = rdata;
  assign m_rlast  = w_rd_ph && w_last_beat;
  assign m_rvalid = w_rd_ph && rvalid;
  assign rready   = w_rd_ph && m_rready;

endmodule
